pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. Decodes hazard conditions from the D, E, M and W stage contents and drives every stage's stall/bubble inputs, including the `execute_stall_i`/`execute_bubble_i` pair of the execute stage. It also runs a drain/halt state machine and a data-memory wait watchdog, and keeps cycle and stall performance counters. It sits beside the pipeline registers in the core top level.

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard-driven stall/bubble generation, drain/halt FSM,
// data-memory wait watchdog and saturating cycle/stall performance counters.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_cnd_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_stall_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;

    localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;

    logic load_use, ret_busy, mispredict, m_exc, w_exc, exc, freeze, wd_expire;

    always_comb begin
        load_use   = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE) &&
                     ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
        ret_busy   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mispredict = (E_icode_i == IJXX) && !e_cnd_i;
        m_exc      = (m_stat_i != SAOK);
        w_exc      = (W_stat_i != SAOK);
        exc        = m_exc || w_exc;
        freeze     = dmem_req_i && !dmem_ack_i;
        wd_expire  = freeze && (wait_cnt == WAIT_LAST);
    end

    // Priority: reset flush, then full hold (HALT or memory freeze), then DRAIN, then hazards.
    always_comb begin
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_stall_o  = 1'b0;
        E_bubble_o = 1'b0;
        M_stall_o  = 1'b0;
        M_bubble_o = 1'b0;
        W_stall_o  = 1'b0;
        if (!rst_n_i) begin
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
        end else if (state == HALT || freeze) begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
        end else if (state == DRAIN) begin
            F_stall_o  = 1'b1;
            D_stall_o  = 1'b1;
            E_stall_o  = 1'b1;
            M_bubble_o = 1'b1;
            W_stall_o  = w_exc;
        end else begin
            F_stall_o  = load_use | ret_busy;
            D_stall_o  = load_use;
            D_bubble_o = mispredict | (ret_busy & ~load_use);
            E_bubble_o = mispredict | load_use;
            M_bubble_o = exc;
            W_stall_o  = w_exc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err_o   <= 1'b0;
            cycle_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (!freeze) begin
                wait_cnt <= '0;
            end else if (!wd_expire) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (wd_expire) begin
                mem_err_o <= 1'b1;
                state     <= HALT;
            end else begin
                case (state)
                    RUN:     if (m_exc && !freeze) state <= DRAIN;
                    DRAIN:   if (w_exc) state <= HALT;
                    default: state <= HALT;
                endcase
            end

            // Counters stop once halted and saturate rather than wrap.
            if (state != HALT) begin
                if (cycle_cnt_o != '1) cycle_cnt_o <= cycle_cnt_o + 1'b1;
                if (F_stall_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end
    end

    assign state_o  = state;
    assign halted_o = (state == HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: combinational hazard table plus multi-cycle
// sequences for load/use, ret, memory wait, watchdog and drain/halt with reset.
module tb_pipe_ctrl;

    localparam logic [3:0] NOP = 4'h1, RMMOV = 4'h4, MRMOV = 4'h5, JXX = 4'h7, RET = 4'h9, POPQ = 4'hB;
    localparam logic [3:0] RN = 4'hF;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd4;
    localparam logic [7:0] HOLD_ALL = 8'b1101_0101;
    localparam logic [7:0] RST_PAT  = 8'b0010_1010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  d_ic, e_ic, m_ic, sa, sb, edm;
    logic        cnd;
    logic [2:0]  ms, ws;
    logic        req, ack;
    logic        f_st, d_st, d_bu, e_st, e_bu, m_st, m_bu, w_st, halted, mem_err;
    logic [1:0]  state;
    logic [31:0] cyc, stl;

    int n_chk = 0;
    int n_fail = 0;

    pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .D_icode_i(d_ic), .E_icode_i(e_ic), .M_icode_i(m_ic),
        .d_srcA_i(sa), .d_srcB_i(sb), .E_dstM_i(edm), .e_cnd_i(cnd),
        .m_stat_i(ms), .W_stat_i(ws), .dmem_req_i(req), .dmem_ack_i(ack),
        .F_stall_o(f_st), .D_stall_o(d_st), .D_bubble_o(d_bu), .E_stall_o(e_st),
        .E_bubble_o(e_bu), .M_stall_o(m_st), .M_bubble_o(m_bu), .W_stall_o(w_st),
        .halted_o(halted), .mem_err_o(mem_err), .state_o(state),
        .cycle_cnt_o(cyc), .stall_cnt_o(stl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] d_ic, e_ic, m_ic, sa, sb, edm;
        logic       cnd;
        logic [2:0] ms, ws;
        logic       req, ack;
        logic [7:0] exp;   // {F_st, D_st, D_bu, E_st, E_bu, M_st, M_bu, W_st}
    } vec_t;

    vec_t vt[14];

    function automatic logic [7:0] ctl();
        return {f_st, d_st, d_bu, e_st, e_bu, m_st, m_bu, w_st};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        d_ic = NOP; e_ic = NOP; m_ic = NOP;
        sa = RN; sb = RN; edm = RN; cnd = 1'b1;
        ms = AOK; ws = AOK; req = 1'b0; ack = 1'b0;
    endtask

    logic [31:0] c0, s0;

    initial begin
        vt[0]  = '{"idle",          NOP,   NOP,   NOP, RN,   RN,   RN,   1'b1, AOK, AOK, 1'b0, 1'b0, 8'b0000_0000};
        vt[1]  = '{"lu_mrmov_srcA", NOP,   MRMOV, NOP, 4'h3, RN,   4'h3, 1'b1, AOK, AOK, 1'b0, 1'b0, 8'b1100_1000};
        vt[2]  = '{"lu_popq_srcB",  NOP,   POPQ,  NOP, 4'h1, 4'h4, 4'h4, 1'b1, AOK, AOK, 1'b0, 1'b0, 8'b1100_1000};
        vt[3]  = '{"lu_no_match",   NOP,   MRMOV, NOP, 4'h2, RN,   4'h3, 1'b1, AOK, AOK, 1'b0, 1'b0, 8'b0000_0000};
        vt[4]  = '{"lu_rnone",      NOP,   MRMOV, NOP, RN,   RN,   RN,   1'b1, AOK, AOK, 1'b0, 1'b0, 8'b0000_0000};
        vt[5]  = '{"lu_store",      NOP,   RMMOV, NOP, 4'h3, RN,   4'h3, 1'b1, AOK, AOK, 1'b0, 1'b0, 8'b0000_0000};
        vt[6]  = '{"ret_in_D",      RET,   NOP,   NOP, RN,   RN,   RN,   1'b1, AOK, AOK, 1'b0, 1'b0, 8'b1010_0000};
        vt[7]  = '{"ret_in_M",      NOP,   NOP,   RET, RN,   RN,   RN,   1'b1, AOK, AOK, 1'b0, 1'b0, 8'b1010_0000};
        vt[8]  = '{"mispredict",    NOP,   JXX,   NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 1'b0, 1'b0, 8'b0010_1000};
        vt[9]  = '{"jxx_taken",     NOP,   JXX,   NOP, RN,   RN,   RN,   1'b1, AOK, AOK, 1'b0, 1'b0, 8'b0000_0000};
        vt[10] = '{"ret_and_lu",    RET,   MRMOV, NOP, 4'h3, RN,   4'h3, 1'b1, AOK, AOK, 1'b0, 1'b0, 8'b1100_1000};
        vt[11] = '{"w_exc_run",     NOP,   NOP,   NOP, RN,   RN,   RN,   1'b1, AOK, HLT, 1'b0, 1'b0, 8'b0000_0011};
        vt[12] = '{"freeze_over_lu",NOP,   MRMOV, NOP, 4'h3, RN,   4'h3, 1'b1, AOK, AOK, 1'b1, 1'b0, HOLD_ALL};
        vt[13] = '{"req_acked_mis", NOP,   JXX,   NOP, RN,   RN,   RN,   1'b0, AOK, AOK, 1'b1, 1'b1, 8'b0010_1000};

        idle();
        rst_n = 1'b0;
        #3;
        chk("rst_ctl", ctl(), RST_PAT);
        chk("rst_state", state, 2'd0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_cycle", cyc, 0);
        chk("rst_stall", stl, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            d_ic = vt[i].d_ic; e_ic = vt[i].e_ic; m_ic = vt[i].m_ic;
            sa = vt[i].sa; sb = vt[i].sb; edm = vt[i].edm; cnd = vt[i].cnd;
            ms = vt[i].ms; ws = vt[i].ws; req = vt[i].req; ack = vt[i].ack;
            #1;
            chk(vt[i].name, ctl(), vt[i].exp);
        end
        @(negedge clk) idle();
        #1;
        chk("table_state_run", state, 2'd0);
        chk("table_no_mem_err", mem_err, 1'b0);

        // Load/use: one stall cycle, both counters advance by one.
        @(negedge clk);
        c0 = cyc; s0 = stl;
        e_ic = MRMOV; edm = 4'h3; sa = 4'h3;
        #1;
        chk("lu_seq_ctl", ctl(), 8'b1100_1000);
        @(negedge clk) idle();
        #1;
        chk("lu_seq_released", ctl(), 8'b0000_0000);
        chk("lu_seq_cycle_delta", cyc - c0, 1);
        chk("lu_seq_stall_delta", stl - s0, 1);

        // Ret walking D -> E -> M, then gone.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle();
            if (k == 0) d_ic = RET;
            if (k == 1) e_ic = RET;
            if (k == 2) m_ic = RET;
            #1;
            chk($sformatf("ret_walk_%0d", k), {f_st, d_bu}, (k < 3) ? 2'b11 : 2'b00);
        end

        // Memory wait of 5 cycles, well inside the watchdog budget.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req = 1'b1; ack = 1'b0;
            #1;
            chk($sformatf("memwait_hold_%0d", k), ctl(), HOLD_ALL);
        end
        @(negedge clk) ack = 1'b1;
        #1;
        chk("memwait_ack_ctl", ctl(), 8'b0000_0000);
        @(negedge clk) idle();
        #1;
        chk("memwait_mem_err", mem_err, 1'b0);
        chk("memwait_state", state, 2'd0);

        // Halt exception: enter DRAIN, then reset asynchronously mid-DRAIN.
        @(negedge clk) ms = HLT;
        #1;
        chk("exc_run_ctl", ctl(), 8'b0000_0010);
        @(negedge clk);
        chk("exc_drain_state", state, 2'd1);
        chk("exc_drain_ctl", ctl(), 8'b1101_0010);
        #2 rst_n = 1'b0;
        #1;
        chk("exc_rst_state", state, 2'd0);
        chk("exc_rst_cycle", cyc, 0);
        chk("exc_rst_stall", stl, 0);
        chk("exc_rst_ctl", ctl(), RST_PAT);
        idle();
        @(negedge clk) rst_n = 1'b1;

        // DRAIN then HALT once W reports halt; HALT is absorbing.
        @(negedge clk) ms = HLT;
        @(negedge clk);
        chk("halt_drain_state", state, 2'd1);
        ws = HLT;
        #1;
        chk("halt_drain_wstall", ctl(), 8'b1101_0011);
        @(negedge clk);
        chk("halt_state", state, 2'd2);
        chk("halt_halted", halted, 1'b1);
        chk("halt_ctl", ctl(), HOLD_ALL);
        chk("halt_mem_err", mem_err, 1'b0);
        c0 = cyc;
        idle();
        repeat (3) @(negedge clk);
        chk("halt_absorbing", state, 2'd2);
        chk("halt_cycle_frozen", cyc, c0);

        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_state", state, 2'd0);
        @(negedge clk) rst_n = 1'b1;

        // Watchdog: ack never arrives; expires on the 16th frozen edge.
        @(negedge clk);
        c0 = cyc;
        req = 1'b1; ack = 1'b0;
        repeat (15) @(negedge clk);
        chk("wd_before_err", mem_err, 1'b0);
        chk("wd_before_state", state, 2'd0);
        @(negedge clk);
        chk("wd_mem_err", mem_err, 1'b1);
        chk("wd_state", state, 2'd2);
        chk("wd_halted", halted, 1'b1);
        chk("wd_cycle_delta", cyc - c0, 16);
        c0 = cyc;
        idle();
        repeat (3) @(negedge clk);
        chk("wd_cycle_frozen", cyc, c0);
        chk("wd_err_sticky", mem_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
